// File: rtl/sha_pipe_pkg.sv
// Shared widths, defaults and FSM encoding for the SHA-256 nonce sequencer.
package sha_pipe_pkg;
    localparam int WORDBITS       = 32;
    localparam int MSGWORDS       = 16;
    localparam int HASHWORDS      = 8;
    localparam int MSGBITS        = WORDBITS * MSGWORDS;
    localparam int HASHBITS       = WORDBITS * HASHWORDS;
    localparam int HITBITS        = WORDBITS + HASHBITS;
    localparam int PIPE_LAT_DEF   = 16;
    localparam int NONCE_WORD_DEF = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    // Top zbits bits set; applied to a digest in D order (H0 most significant).
    function automatic logic [HASHBITS-1:0] lz_mask(input logic [7:0] zbits);
        return ~({HASHBITS{1'b1}} >> zbits);
    endfunction

    // hash_in packs H0 in the low word; D wants H0 in the high word.
    function automatic logic [HASHBITS-1:0] digest_order(input logic [HASHBITS-1:0] h);
        logic [HASHBITS-1:0] d;
        for (int i = 0; i < HASHWORDS; i++)
            d[HASHBITS-1-WORDBITS*i -: WORDBITS] = h[WORDBITS*i +: WORDBITS];
        return d;
    endfunction
endpackage

// File: rtl/sha_hit_fifo2.sv
// Two-entry valid/ready FIFO holding {nonce, digest} hits.
module sha_hit_fifo2 #(
    parameter int W = 288
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_full
);
    logic [1:0][W-1:0] r_mem;
    logic              r_rd, r_wr;
    logic [1:0]        r_cnt;
    logic              w_pop, w_push;

    assign o_valid = (r_cnt != 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign o_data  = r_mem[r_rd];
    assign w_pop   = o_valid && i_ready;
    // A full FIFO still takes a push in the same clock as a pop.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop)
                r_rd <= ~r_rd;
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 2'd1;
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - 2'd1;
        end
    end
endmodule

// File: rtl/sha_nonce_sequencer.sv
// Issues nonce-substituted blocks into a fixed-latency SHA-256 pipeline and screens
// the returning digests against a leading-zero target, queueing qualifying hits.
module sha_nonce_sequencer
    import sha_pipe_pkg::*;
#(
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int NONCE_WORD = NONCE_WORD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [MSGBITS-1:0]  job_template,
    input  logic [WORDBITS-1:0] job_start,
    input  logic [WORDBITS-1:0] job_end,
    input  logic [7:0]          job_zbits,
    input  logic                job_abort,
    output logic [MSGBITS-1:0]  msg_out,
    input  logic [HASHBITS-1:0] hash_in,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [WORDBITS-1:0] hit_nonce,
    output logic [HASHBITS-1:0] hit_hash,
    output logic                busy,
    output logic                done,
    output logic [15:0]         hit_drops
);
    state_t                            r_state;
    logic                              r_job_ready, r_busy, r_done;
    logic [MSGBITS-1:0]                r_msg, r_tpl;
    logic [WORDBITS-1:0]               r_nonce, r_end;
    logic [7:0]                        r_zbits;
    logic [PIPE_LAT-1:0]               r_tag_vld;
    logic [PIPE_LAT-1:0][WORDBITS-1:0] r_tag_nonce;
    logic [15:0]                       r_drops;

    logic [MSGBITS-1:0]                w_issue_msg;
    logic                              w_hit, w_full, w_drop;
    logic [HITBITS-1:0]                w_hit_data;

    always_comb begin
        w_issue_msg = r_tpl;
        w_issue_msg[NONCE_WORD*WORDBITS +: WORDBITS] = r_nonce;
    end

    // The tail tag is exactly aligned with the digest currently on hash_in.
    assign w_hit  = r_tag_vld[PIPE_LAT-1] &&
                    ((digest_order(hash_in) & lz_mask(r_zbits)) == '0);
    assign w_drop = w_hit && w_full && !(hit_valid && hit_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_msg       <= '0;
            r_tpl       <= '0;
            r_nonce     <= '0;
            r_end       <= '0;
            r_zbits     <= '0;
            r_tag_vld   <= '0;
            r_tag_nonce <= '0;
            r_drops     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_tag_vld   <= {r_tag_vld[PIPE_LAT-2:0], 1'b0};
            r_tag_nonce <= {r_tag_nonce[PIPE_LAT-2:0], r_nonce};
            if (w_drop && r_drops != 16'hFFFF)
                r_drops <= r_drops + 16'd1;
            case (r_state)
                IDLE: if (job_valid) begin
                    r_state     <= ISSUE;
                    r_job_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    r_tpl       <= job_template;
                    r_nonce     <= job_start;
                    r_end       <= job_end;
                    r_zbits     <= job_zbits;
                    r_drops     <= '0;
                end
                ISSUE: if (job_abort) begin
                    r_state     <= IDLE;
                    r_job_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_tag_vld   <= '0;
                end else begin
                    r_msg        <= w_issue_msg;
                    r_tag_vld[0] <= 1'b1;
                    r_nonce      <= r_nonce + 32'd1;
                    if (r_nonce == r_end)
                        r_state <= DRAIN;
                end
                DRAIN: if (job_abort) begin
                    r_state     <= IDLE;
                    r_job_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_tag_vld   <= '0;
                end else if (r_tag_vld[PIPE_LAT-2:0] == '0) begin
                    // The tail is screened this clock, so the line is empty after it.
                    r_state     <= IDLE;
                    r_job_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sha_hit_fifo2 #(.W(HITBITS)) u_hit_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_hit),
        .i_data  ({r_tag_nonce[PIPE_LAT-1], hash_in}),
        .o_valid (hit_valid),
        .i_ready (hit_ready),
        .o_data  (w_hit_data),
        .o_full  (w_full)
    );

    assign job_ready = r_job_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign msg_out   = r_msg;
    assign hit_drops = r_drops;
    assign hit_nonce = w_hit_data[HITBITS-1 -: WORDBITS];
    assign hit_hash  = w_hit_data[HASHBITS-1:0];
endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Bench for sha_nonce_sequencer using a fixed-latency stub pipeline whose digest
// carries the nonce in H0 and template words in H1..H7.
module tb_sha_nonce_sequencer;
    localparam int L  = 16;
    localparam int NW = 3;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         job_valid = 1'b0, job_abort = 1'b0, hit_ready = 1'b1;
    logic         job_ready, hit_valid, busy, done;
    logic [511:0] job_template = '0, msg_out;
    logic [31:0]  job_start = '0, job_end = '0, hit_nonce;
    logic [7:0]   job_zbits = '0;
    logic [255:0] hash_in, hit_hash;
    logic [15:0]  hit_drops;

    sha_nonce_sequencer #(.PIPE_LAT(L), .NONCE_WORD(NW)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_template(job_template), .job_start(job_start), .job_end(job_end),
        .job_zbits(job_zbits), .job_abort(job_abort), .msg_out(msg_out),
        .hash_in(hash_in), .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_nonce(hit_nonce), .hit_hash(hit_hash), .busy(busy), .done(done),
        .hit_drops(hit_drops)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] stub_fn(input logic [511:0] m);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = m[32*((NW+i)%16) +: 32];
        return h;
    endfunction

    // msg_out is already one register; L-1 more make the digest sampled L clocks later.
    logic [255:0] sp [L-1];
    initial for (int i = 0; i < L-1; i++) sp[i] = '0;
    always @(posedge clk) begin
        sp[0] <= stub_fn(msg_out);
        for (int i = 1; i < L-1; i++) sp[i] <= sp[i-1];
    end
    assign hash_in = sp[L-2];

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  hq_n[$], en[$];
    logic [255:0] hq_h[$], eh[$];
    int           dq[$], aq[$];
    always @(negedge clk) if (rst_n) begin
        if (hit_valid && hit_ready) begin hq_n.push_back(hit_nonce); hq_h.push_back(hit_hash); end
        if (done) dq.push_back(cyc);
        if (job_valid && job_ready) aq.push_back(cyc + 1);
    end

    function automatic logic [255:0] model_hash(input logic [31:0] n, input logic [511:0] tpl);
        logic [511:0] m;
        m = tpl;
        m[32*NW +: 32] = n;
        return stub_fn(m);
    endfunction

    function automatic int clz(input logic [255:0] h);
        for (int w = 0; w < 8; w++)
            for (int b = 31; b >= 0; b--)
                if (h[32*w+b]) return 32*w + (31-b);
        return 256;
    endfunction

    task automatic model_job(input logic [31:0] s, input logic [31:0] e, input int z, input logic [511:0] tpl);
        logic [31:0] n;
        n = s;
        en.delete(); eh.delete();
        while (1) begin
            if (clz(model_hash(n, tpl)) >= z) begin en.push_back(n); eh.push_back(model_hash(n, tpl)); end
            if (n == e) break;
            n = n + 32'd1;
        end
    endtask

    task automatic step(); @(posedge clk); #1; endtask
    task automatic clear_q(); hq_n.delete(); hq_h.delete(); dq.delete(); aq.delete(); endtask

    function automatic logic [511:0] rand_tpl();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom;
        return t;
    endfunction

    task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [7:0] z, input logic [511:0] tpl);
        job_template = tpl; job_start = s; job_end = e; job_zbits = z; job_valid = 1'b1;
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin step(); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL wait_idle: busy still %0b after %0d clocks, required 0", busy, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL reset_job_ready: got %0b want 1", job_ready); end
        checks++; if (msg_out !== '0) begin failures++; $display("FAIL reset_msg_out: got %h want 0", msg_out); end
        checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL reset_hit_valid: got %0b want 0", hit_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
        checks++; if (hit_drops !== 16'd0) begin failures++; $display("FAIL reset_drops: got %0d want 0", hit_drops); end
        rst_n = 1'b1;
        step();
        checks++; if (job_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: ready %0b busy %0b want 1 0", job_ready, busy); end
    endtask

    task automatic test_single();
        logic [511:0] tpl, em;
        logic [31:0]  s;
        clear_q();
        tpl = rand_tpl(); s = $urandom;
        start_job(s, s, 8'd0, tpl);
        wait_idle(60); step(); step();
        em = tpl; em[32*NW +: 32] = s;
        checks++; if (msg_out !== em) begin failures++; $display("FAIL single_msg_out: got %h want %h", msg_out, em); end
        checks++; if (dq.size() != 1 || aq.size() != 1) begin failures++; $display("FAIL single_done_count: done %0d accept %0d want 1 1", dq.size(), aq.size()); end
        else begin
            checks++; if (dq[0] - aq[0] != L + 1) begin failures++; $display("FAIL single_done_latency: got %0d want %0d", dq[0] - aq[0], L + 1); end
        end
        checks++; if (hq_n.size() != 1) begin failures++; $display("FAIL single_hit_count: got %0d want 1", hq_n.size()); end
        else begin
            checks++; if (hq_n[0] !== s) begin failures++; $display("FAIL single_hit_nonce: got %h want %h", hq_n[0], s); end
            checks++; if (hq_h[0] !== model_hash(s, tpl)) begin failures++; $display("FAIL single_hit_hash: got %h want %h", hq_h[0], model_hash(s, tpl)); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0]  exp4 [4];
        logic [511:0] tpl;
        exp4 = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        tpl = rand_tpl();
        for (int pass = 0; pass < 2; pass++) begin
            clear_q();
            start_job(32'hFFFFFFFE, 32'h1, (pass == 0) ? 8'd1 : 8'd0, tpl);
            wait_idle(60); step(); step();
            if (pass == 0) begin
                checks++; if (hq_n.size() != 2) begin failures++; $display("FAIL wrap_z1_count: got %0d want 2", hq_n.size()); end
                else begin
                    checks++; if (hq_n[0] !== 32'h0 || hq_n[1] !== 32'h1) begin failures++; $display("FAIL wrap_z1_nonces: got %h %h want 0 1", hq_n[0], hq_n[1]); end
                end
            end else begin
                checks++; if (hq_n.size() != 4) begin failures++; $display("FAIL wrap_z0_count: got %0d want 4", hq_n.size()); end
                else for (int i = 0; i < 4; i++) begin
                    checks++; if (hq_n[i] !== exp4[i]) begin failures++; $display("FAIL wrap_z0_nonce%0d: got %h want %h", i, hq_n[i], exp4[i]); end
                end
            end
        end
    endtask

    task automatic test_drops();
        logic [31:0] s;
        clear_q();
        s = $urandom;
        hit_ready = 1'b0;
        start_job(s, s + 32'd7, 8'd0, rand_tpl());
        wait_idle(60); step();
        checks++; if (hit_valid !== 1'b1 || hit_nonce !== s) begin failures++; $display("FAIL drops_head: valid %0b nonce %h want 1 %h", hit_valid, hit_nonce, s); end
        checks++; if (hit_drops !== 16'd6) begin failures++; $display("FAIL drops_count: got %0d want 6", hit_drops); end
        checks++; if (dq.size() != 1) begin failures++; $display("FAIL drops_done: got %0d want 1", dq.size()); end
        hit_ready = 1'b1;
        repeat (5) step();
        checks++; if (hq_n.size() != 2) begin failures++; $display("FAIL drops_pops: got %0d want 2", hq_n.size()); end
        else begin
            checks++; if (hq_n[0] !== s || hq_n[1] !== s + 32'd1) begin failures++; $display("FAIL drops_pop_order: got %h %h want %h %h", hq_n[0], hq_n[1], s, s + 32'd1); end
        end
        checks++; if (hit_valid !== 1'b0 || hit_drops !== 16'd6) begin failures++; $display("FAIL drops_after: valid %0b drops %0d want 0 6", hit_valid, hit_drops); end
    endtask

    task automatic test_abort();
        logic [31:0] s;
        clear_q();
        s = $urandom;
        start_job(s, s + 32'd99, 8'd0, rand_tpl());
        repeat (4) step();
        job_abort = 1'b1;
        step();
        job_abort = 1'b0;
        checks++; if (busy !== 1'b0 || job_ready !== 1'b1) begin failures++; $display("FAIL abort_idle: busy %0b ready %0b want 0 1", busy, job_ready); end
        repeat (L + 4) step();
        checks++; if (hq_n.size() != 0 || dq.size() != 0) begin failures++; $display("FAIL abort_quiet: hits %0d dones %0d want 0 0", hq_n.size(), dq.size()); end
        clear_q();
        s = $urandom;
        start_job(s, s + 32'd2, 8'd0, rand_tpl());
        wait_idle(60); step(); step();
        checks++; if (hq_n.size() != 3 || dq.size() != 1) begin failures++; $display("FAIL abort_next_count: hits %0d dones %0d want 3 1", hq_n.size(), dq.size()); end
        else begin
            checks++; if (hq_n[0] !== s || hq_n[2] !== s + 32'd2) begin failures++; $display("FAIL abort_next_tags: got %h %h want %h %h", hq_n[0], hq_n[2], s, s + 32'd2); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_q();
        job_template = rand_tpl(); job_start = $urandom; job_end = job_start + 32'd2; job_zbits = 8'd0;
        job_valid = 1'b1;
        n = 0;
        while (aq.size() < 2 && n < 100) begin step(); n++; end
        job_valid = 1'b0;
        checks++; if (aq.size() != 2 || dq.size() != 1) begin failures++; $display("FAIL b2b_counts: accepts %0d dones %0d want 2 1", aq.size(), dq.size()); end
        else begin
            checks++; if (aq[1] != dq[0] + 1) begin failures++; $display("FAIL b2b_accept_cycle: got %0d want %0d", aq[1], dq[0] + 1); end
        end
        repeat (5) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_draining: busy %0b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (job_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_ctl: ready %0b busy %0b done %0b want 1 0 0", job_ready, busy, done); end
        checks++; if (msg_out !== '0 || hit_valid !== 1'b0 || hit_drops !== 16'd0) begin failures++; $display("FAIL async_reset_data: msg %h valid %0b drops %0d want 0", msg_out, hit_valid, hit_drops); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [511:0] tpl;
        logic [31:0]  s;
        int           len, z;
        for (int j = 0; j < 8; j++) begin
            clear_q();
            tpl = rand_tpl();
            if ($urandom_range(0, 1) == 1) tpl[32*(NW+1) +: 32] = '0;
            if ($urandom_range(0, 2) == 0) s = 32'hFFFFFFFF - $urandom_range(0, 6);
            else s = $urandom >> $urandom_range(0, 31);
            len = $urandom_range(1, 12);
            z = $urandom_range(0, 36);
            model_job(s, s + len - 1, z, tpl);
            start_job(s, s + len - 1, 8'(z), tpl);
            wait_idle(80); step(); step();
            checks++; if (hq_n.size() != en.size() || dq.size() != 1) begin
                failures++; $display("FAIL rand%0d_count: hits %0d dones %0d want %0d 1 (s=%h len=%0d z=%0d)", j, hq_n.size(), dq.size(), en.size(), s, len, z);
            end else for (int i = 0; i < en.size(); i++) begin
                checks++; if (hq_n[i] !== en[i] || hq_h[i] !== eh[i]) begin failures++; $display("FAIL rand%0d_hit%0d: got %h want %h", j, i, hq_n[i], en[i]); end
            end
            checks++; if (hit_drops !== 16'd0) begin failures++; $display("FAIL rand%0d_drops: got %0d want 0", j, hit_drops); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_drops();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
